// File: rtl/bcd_display_seq.sv
// Sequential binary to N_DIG-digit seven-segment converter: one double-dabble shift per clock,
// start/busy/done handshake, overflow dash display and optional leading-zero blanking.
module bcd_display_seq #(
    parameter int unsigned N_in  = 10,
    parameter int unsigned N_DIG = 4,
    parameter int unsigned N_out = 7
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [N_in-1:0]          bin_in,
    input  logic                     blank_lz,
    output logic                     busy,
    output logic                     done,
    output logic                     ovf,
    output logic [4*N_DIG-1:0]       bcd_out,
    output logic [N_out*N_DIG-1:0]   seg_out
);

    localparam int unsigned ND_INT = (N_in + 2) / 3;
    localparam int unsigned ND_EXT = (ND_INT > N_DIG) ? ND_INT : N_DIG;
    localparam int unsigned BCD_W  = 4 * ND_INT;
    localparam int unsigned EXT_W  = 4 * ND_EXT;
    localparam int unsigned OUT_W  = 4 * N_DIG;
    localparam int unsigned SEG_W  = N_out * N_DIG;
    localparam int unsigned CNT_W  = $clog2(N_in + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    logic [1:0]        state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [N_in-1:0]   bin_sh, bin_nxt;
    logic [BCD_W-1:0]  bcd_q, bcd_nxt;
    logic              blank_q, blank_nxt;
    logic              busy_nxt, done_nxt, ovf_nxt;
    logic [OUT_W-1:0]  bcd_out_nxt;
    logic [SEG_W-1:0]  seg_nxt;

    logic [BCD_W-1:0]  adj;
    logic [EXT_W-1:0]  bcd_ext;
    logic              ovf_c;
    logic [SEG_W-1:0]  seg_c;
    logic              lz_run;
    logic [3:0]        dig;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b1000000;
            4'd1:    seg_of = 7'b1111001;
            4'd2:    seg_of = 7'b0100100;
            4'd3:    seg_of = 7'b0110000;
            4'd4:    seg_of = 7'b0011001;
            4'd5:    seg_of = 7'b0010010;
            4'd6:    seg_of = 7'b0000010;
            4'd7:    seg_of = 7'b1111000;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0010000;
            default: seg_of = SEG_BLANK;
        endcase
    endfunction

    // Double-dabble correction: every digit >= 5 gets +3 before the shift
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < int'(ND_INT); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    assign bcd_ext = EXT_W'(bcd_q);

    // Overflow only possible when the internal register has digits beyond the display
    generate
        if (ND_EXT > N_DIG) begin : g_ovf
            assign ovf_c = |bcd_ext[EXT_W-1:OUT_W];
        end else begin : g_no_ovf
            assign ovf_c = 1'b0;
        end
    endgenerate

    // Segment decode, scanning from the top digit so leading zeros can be blanked
    always_comb begin
        seg_c  = '1;
        lz_run = 1'b1;
        dig    = 4'd0;
        for (int i = int'(N_DIG) - 1; i >= 0; i--) begin
            dig = bcd_ext[4*i +: 4];
            if (dig != 4'd0) begin
                lz_run = 1'b0;
            end
            if (ovf_c) begin
                seg_c[N_out*i +: N_out] = N_out'(SEG_DASH);
            end else if (blank_q && lz_run && (i != 0)) begin
                seg_c[N_out*i +: N_out] = N_out'(SEG_BLANK);
            end else begin
                seg_c[N_out*i +: N_out] = N_out'(seg_of(dig));
            end
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bin_nxt     = bin_sh;
        bcd_nxt     = bcd_q;
        blank_nxt   = blank_q;
        done_nxt    = 1'b0;
        ovf_nxt     = ovf;
        bcd_out_nxt = bcd_out;
        seg_nxt     = seg_out;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    bin_nxt   = bin_in;
                    blank_nxt = blank_lz;
                    bcd_nxt   = '0;
                    cnt_nxt   = CNT_W'(N_in);
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bcd_nxt = {adj[BCD_W-2:0], bin_sh[N_in-1]};
                bin_nxt = {bin_sh[N_in-2:0], 1'b0};
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                bcd_out_nxt = bcd_ext[OUT_W-1:0];
                seg_nxt     = seg_c;
                ovf_nxt     = ovf_c;
                done_nxt    = 1'b1;
                state_nxt   = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        busy_nxt = (state_nxt == ST_SHIFT) || (state_nxt == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bin_sh  <= '0;
            bcd_q   <= '0;
            blank_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ovf     <= 1'b0;
            bcd_out <= '0;
            seg_out <= '1;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bin_sh  <= bin_nxt;
            bcd_q   <= bcd_nxt;
            blank_q <= blank_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            ovf     <= ovf_nxt;
            bcd_out <= bcd_out_nxt;
            seg_out <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_display_seq.sv
// Directed bench for bcd_display_seq: a 10-bit/4-digit instance and a 14-bit/4-digit
// instance for the overflow path, plus a back-to-back sweep against a /10, %10 model.
module tb_bcd_display_seq;

    logic clk = 1'b0;
    logic rst_n;

    logic        start_a, blank_a;
    logic [9:0]  bin_a;
    logic        busy_a, done_a, ovf_a;
    logic [15:0] bcd_a;
    logic [27:0] seg_a;

    logic        start_b, blank_b;
    logic [13:0] bin_b;
    logic        busy_b, done_b, ovf_b;
    logic [15:0] bcd_b;
    logic [27:0] seg_b;

    int checks   = 0;
    int failures = 0;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                           S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                           S9 = 7'b0010000, SB = 7'b1111111, SD = 7'b0111111;

    always #5 clk = ~clk;

    bcd_display_seq #(.N_in(10), .N_DIG(4), .N_out(7)) dut (
        .clk(clk), .rst_n(rst_n), .start(start_a), .bin_in(bin_a), .blank_lz(blank_a),
        .busy(busy_a), .done(done_a), .ovf(ovf_a), .bcd_out(bcd_a), .seg_out(seg_a)
    );

    bcd_display_seq #(.N_in(14), .N_DIG(4), .N_out(7)) dut14 (
        .clk(clk), .rst_n(rst_n), .start(start_b), .bin_in(bin_b), .blank_lz(blank_b),
        .busy(busy_b), .done(done_b), .ovf(ovf_b), .bcd_out(bcd_b), .seg_out(seg_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg7(input int d);
        case (d)
            0: seg7 = S0; 1: seg7 = S1; 2: seg7 = S2; 3: seg7 = S3; 4: seg7 = S4;
            5: seg7 = S5; 6: seg7 = S6; 7: seg7 = S7; 8: seg7 = S8; 9: seg7 = S9;
            default: seg7 = SB;
        endcase
    endfunction

    // Reference: decimal digits by repeated /10, %10
    task automatic model(input int v, input bit blz, output logic [15:0] b,
                         output logic [27:0] s, output bit o);
        int d[4];
        int t;
        int msd;
        t   = v;
        msd = 0;
        b   = '0;
        o   = (v >= 10000);
        for (int i = 0; i < 4; i++) begin
            d[i] = t % 10;
            t    = t / 10;
            b[4*i +: 4] = 4'(d[i]);
            if (d[i] != 0) msd = i;
        end
        for (int i = 0; i < 4; i++) begin
            if (o)                 s[7*i +: 7] = SD;
            else if (blz && i > msd) s[7*i +: 7] = SB;
            else                   s[7*i +: 7] = seg7(d[i]);
        end
    endtask

    // Issue one start and count edges until done (lat = -1 on timeout)
    task automatic convert(input bit sel, input int v, input bit blz, output int lat);
        @(negedge clk);
        if (sel) begin
            bin_b = 14'(v); blank_b = blz; start_b = 1'b1;
        end else begin
            bin_a = 10'(v); blank_a = blz; start_a = 1'b1;
        end
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (sel ? done_b : done_a) begin
                lat = k;
                break;
            end
        end
    endtask

    int          lat;
    int          k;
    bit          changed;
    bit          busy_drop;
    logic [15:0] eb;
    logic [27:0] es;
    bit          eo;

    initial begin
        rst_n = 1'b0;
        start_a = 1'b0; blank_a = 1'b0; bin_a = '0;
        start_b = 1'b0; blank_b = 1'b0; bin_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_done", 64'(done_a), 64'd0);
        check("rst_ovf",  64'(ovf_a),  64'd0);
        check("rst_bcd",  64'(bcd_a),  64'd0);
        check("rst_seg",  64'(seg_a),  64'hFFF_FFFF);
        @(negedge clk);
        rst_n = 1'b1;

        // Full-scale value, no blanking
        convert(1'b0, 1023, 1'b0, lat);
        check("lat_1023", 64'(lat), 64'd11);
        check("bcd_1023", 64'(bcd_a), 64'h1023);
        check("ovf_1023", 64'(ovf_a), 64'd0);
        check("seg_1023", 64'(seg_a), 64'({S1, S0, S2, S3}));
        @(posedge clk);
        #1;
        check("done_pulse", 64'(done_a), 64'd0);

        convert(1'b0, 7, 1'b1, lat);
        check("seg_7_blz", 64'(seg_a), 64'({SB, SB, SB, S7}));
        check("bcd_7", 64'(bcd_a), 64'h0007);
        convert(1'b0, 0, 1'b1, lat);
        check("seg_0_blz", 64'(seg_a), 64'({SB, SB, SB, S0}));
        convert(1'b0, 0, 1'b0, lat);
        check("seg_0_noblz", 64'(seg_a), 64'({S0, S0, S0, S0}));

        // Reset mid-conversion discards it
        @(negedge clk);
        bin_a = 10'd512; blank_a = 1'b0; start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy_a), 64'd0);
        check("midrst_done", 64'(done_a), 64'd0);
        check("midrst_seg",  64'(seg_a),  64'hFFF_FFFF);
        check("midrst_bcd",  64'(bcd_a),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        convert(1'b0, 89, 1'b1, lat);
        check("lat_89", 64'(lat), 64'd11);
        check("bcd_89", 64'(bcd_a), 64'h0089);
        check("seg_89", 64'(seg_a), 64'({SB, SB, S8, S9}));

        // Second start during SHIFT is ignored; outputs hold until done
        @(negedge clk);
        bin_a = 10'd456; blank_a = 1'b0; start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        changed = 1'b0;
        busy_drop = 1'b0;
        lat = -1;
        for (k = 1; k <= 40; k++) begin
            if (k == 3) begin
                bin_a = 10'd999; blank_a = 1'b1; start_a = 1'b1;
            end else begin
                start_a = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done_a) begin
                lat = k;
                break;
            end
            if (!busy_a) busy_drop = 1'b1;
            if (bcd_a !== 16'h0089 || seg_a !== {SB, SB, S8, S9}) changed = 1'b1;
        end
        start_a = 1'b0;
        check("hold_outputs", 64'(changed), 64'd0);
        check("busy_held", 64'(busy_drop), 64'd0);
        check("lat_456", 64'(lat), 64'd11);
        check("bcd_456", 64'(bcd_a), 64'h0456);
        check("seg_456", 64'(seg_a), 64'({S0, S4, S5, S6}));
        repeat (3) @(posedge clk);
        #1;
        check("ignored_start", 64'(busy_a), 64'd0);

        // 14-bit instance: overflow boundaries
        convert(1'b1, 12345, 1'b0, lat);
        check("lat_14b", 64'(lat), 64'd15);
        check("ovf_12345", 64'(ovf_b), 64'd1);
        check("bcd_12345", 64'(bcd_b), 64'h2345);
        check("seg_12345", 64'(seg_b), 64'({SD, SD, SD, SD}));
        convert(1'b1, 9999, 1'b1, lat);
        check("ovf_9999", 64'(ovf_b), 64'd0);
        check("bcd_9999", 64'(bcd_b), 64'h9999);
        check("seg_9999", 64'(seg_b), 64'({S9, S9, S9, S9}));
        convert(1'b1, 10000, 1'b1, lat);
        check("ovf_10000", 64'(ovf_b), 64'd1);
        check("bcd_10000", 64'(bcd_b), 64'h0000);
        check("seg_10000", 64'(seg_b), 64'({SD, SD, SD, SD}));
        convert(1'b1, 16383, 1'b0, lat);
        check("ovf_16383", 64'(ovf_b), 64'd1);
        check("bcd_16383", 64'(bcd_b), 64'h6383);

        // Back-to-back sweep with start held high
        @(negedge clk);
        bin_a = 10'd0; blank_a = 1'b0; start_a = 1'b1;
        for (int v = 0; v < 1024; v++) begin
            lat = -1;
            for (int j = 1; j <= 40; j++) begin
                @(posedge clk);
                #1;
                if (done_a) begin
                    lat = j;
                    break;
                end
            end
            if (lat < 0) begin
                check("sweep_timeout", 64'd0, 64'd1);
                break;
            end
            bin_a   = 10'(v + 1);
            blank_a = (((v + 1) % 2) == 1);
            model(v, (v % 2) == 1, eb, es, eo);
            if (v > 0) check("sweep_period", 64'(lat), 64'd12);
            check("sweep_bcd", 64'(bcd_a), 64'(eb));
            check("sweep_seg", 64'(seg_a), 64'(es));
            check("sweep_ovf", 64'(ovf_a), 64'(eo));
        end
        start_a = 1'b0;
        repeat (15) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
